mem_port_scheduler: RTL
=======================

MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of requesters (port 0 = icache, 1 = dcache, 2 = auxiliary/DMA).
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the address width.
REQ-003 The block SHALL have parameter DATA_W, default 128, giving the block/line data width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 1024, giving the response watchdog limit in cycles.
REQ-005 The block SHALL have a single clock: clk_i, input, 1 bit.
REQ-006 The block SHALL have rst_i, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have req_valid_i, input, NUM_REQ bits: per-requester request valid.
REQ-008 The block SHALL have req_addr_i, input, NUM_REQ*ADDR_W bits: packed per-requester address.
REQ-009 The block SHALL have req_data_i, input, NUM_REQ*DATA_W bits: packed write data.
REQ-010 The block SHALL have req_be_i, input, NUM_REQ*(DATA_W/8) bits: byte enables, all-zero = read.
REQ-011 The block SHALL have req_ready_o, output, NUM_REQ bits: one-hot request accept.
REQ-012 The block SHALL have res_valid_o, output, NUM_REQ bits: one-hot response pulse.
REQ-013 The block SHALL have res_data_o, output, DATA_W bits: response data shared by all requesters.
REQ-014 The block SHALL have res_err_o, output, 1 bit: response error qualifier, valid with res_valid_o.
REQ-015 The block SHALL have mem_req_valid_o, output, 1 bit: memory request valid.
REQ-016 The block SHALL have mem_req_addr_o, output, ADDR_W bits: memory request address.
REQ-017 The block SHALL have mem_req_data_o, output, DATA_W bits: memory request write data.
REQ-018 The block SHALL have mem_req_be_o, output, DATA_W/8 bits: memory request byte enables.
REQ-019 The block SHALL have mem_req_ready_i, input, 1 bit: memory accepts the request.
REQ-020 The block SHALL have mem_res_valid_i, input, 1 bit: memory response valid.
REQ-021 The block SHALL have mem_res_data_i, input, DATA_W bits: memory response data.
REQ-022 The block SHALL have busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-023 The block SHALL have timeout_o, output, 1 bit: sticky watchdog flag.

Function
REQ-024 The FSM SHALL have exactly three states, IDLE, ISSUE and WAIT, with at most one memory transaction outstanding.
REQ-025 In IDLE with any req_valid_i bit set, the block SHALL select grant g, the first valid index at or after rr_ptr with modulo-NUM_REQ wrap, assert req_ready_o[g] for that cycle only, latch g and that requester's addr/data/be, set rr_ptr to (g+1) mod NUM_REQ, and enter ISSUE.
REQ-026 req_ready_o SHALL be zero in ISSUE and WAIT; requesters hold valid and payload until accepted.
REQ-027 In ISSUE, mem_req_valid_o SHALL be 1 and drive the latched payload; when mem_req_ready_i=1, the FSM SHALL enter WAIT on the next cycle.
REQ-028 mem_req_valid_o SHALL be 0 in IDLE and WAIT, and the mem_req_* payload SHALL be stable while mem_req_valid_o=1.
REQ-029 In WAIT, on mem_res_valid_i=1, the block SHALL pulse res_valid_o[g] for exactly one cycle in that same cycle, with res_data_o=mem_res_data_i and res_err_o=0, and then return to IDLE.
REQ-030 mem_res_valid_i SHALL be ignored in IDLE and ISSUE.
REQ-031 Minimum latency SHALL be: request accepted in cycle 0, ISSUE in cycle 1, WAIT from cycle 2, response visible in the cycle mem_res_valid_i rises, and the next grant possible one cycle after the response.
REQ-032 Simultaneous requests SHALL be served strictly round-robin, so no requester waits more than NUM_REQ-1 grants.
REQ-033 When res_valid_o is zero, res_data_o SHALL be zero.

Reset
REQ-034 While rst_i=1 at a clock edge, the state SHALL go to IDLE, rr_ptr to 0, the watchdog counter to 0, the latched payload to 0 and timeout_o to 0.
REQ-035 After reset, all outputs SHALL be zero; reset asserted mid-transaction SHALL abandon that transaction with no res_valid_o pulse.

Configuration
REQ-036 With MEM_SCHED_TIMEOUT_EN defined, a counter SHALL be cleared on entry to WAIT and increment each WAIT cycle; when it reaches TIMEOUT_CYC-1 without a response, the block SHALL pulse res_valid_o[g] with res_err_o=1 and res_data_o=0, set timeout_o, and return to IDLE.
REQ-037 With MEM_SCHED_TIMEOUT_EN defined, a response arriving in the same cycle as the timeout SHALL win (res_err_o=0).
REQ-038 Without MEM_SCHED_TIMEOUT_EN, the block SHALL contain no counter, WAIT SHALL hold indefinitely, and res_err_o and timeout_o SHALL be tied to 0.

Verification
REQ-039 The bench SHALL check: req_valid_i=3'b111 held, memory ready and response 2 cycles after accept -> grants in order 0,1,2,0; each res_valid_o one-hot and one cycle wide.
REQ-040 The bench SHALL check: req_valid_i=3'b010, addr 0x8000_0040, be=all-ones, data 0xA5.. -> mem_req_* carries exactly those values; res_valid_o=3'b010.
REQ-041 The bench SHALL check: mem_req_ready_i held low 5 cycles -> mem_req_valid_o stays 1 with unchanged payload and req_ready_o=0.
REQ-042 The bench SHALL check: rst_i asserted in WAIT -> next cycle busy_o=0, no res_valid_o, rr_ptr=0 (next grant on 3'b111 is port 0).
REQ-043 The bench SHALL check, with MEM_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, no response -> res_valid_o[g]=1 and res_err_o=1 8 cycles after entering WAIT, then timeout_o=1 until reset.
REQ-044 The bench SHALL check: mem_res_valid_i pulsed while in IDLE -> no res_valid_o.

Source files
------------

// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler funnelling NUM_REQ requesters onto one single-outstanding memory port.
// Optional response watchdog enabled by defining MEM_SCHED_TIMEOUT_EN.
module mem_port_scheduler #(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_be_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [NUM_REQ-1:0]           res_valid_o,
    output logic [DATA_W-1:0]            res_data_o,
    output logic                         res_err_o,
    output logic                         mem_req_valid_o,
    output logic [ADDR_W-1:0]            mem_req_addr_o,
    output logic [DATA_W-1:0]            mem_req_data_o,
    output logic [DATA_W/8-1:0]          mem_req_be_o,
    input  logic                         mem_req_ready_i,
    input  logic                         mem_res_valid_i,
    input  logic [DATA_W-1:0]            mem_res_data_i,
    output logic                         busy_o,
    output logic                         timeout_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d, gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [BE_W-1:0]    be_q, be_d;

    logic               sel_found;
    logic [PTR_W-1:0]   sel_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic [BE_W-1:0]    sel_be;
    int unsigned        idx;
    logic               res_fire, res_err;

`ifdef MEM_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;
`endif

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sel_be    = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_q) + i) % NUM_REQ;
            if (!sel_found && req_valid_i[PTR_W'(idx)]) begin
                sel_found = 1'b1;
                sel_idx   = PTR_W'(idx);
                sel_addr  = req_addr_i[idx*ADDR_W +: ADDR_W];
                sel_data  = req_data_i[idx*DATA_W +: DATA_W];
                sel_be    = req_be_i[idx*BE_W +: BE_W];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_d            = rr_q;
        gnt_d           = gnt_q;
        addr_d          = addr_q;
        data_d          = data_q;
        be_d            = be_q;
        req_ready_o     = '0;
        mem_req_valid_o = 1'b0;
        res_fire        = 1'b0;
        res_err         = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found && !rst_i) begin
                    req_ready_o[sel_idx] = 1'b1;
                    gnt_d   = sel_idx;
                    addr_d  = sel_addr;
                    data_d  = sel_data;
                    be_d    = sel_be;
                    rr_d    = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_res_valid_i) begin
                    res_fire = 1'b1;
                    state_d  = IDLE;
                end
`ifdef MEM_SCHED_TIMEOUT_EN
                else if (cnt_q == CNT_MAX) begin
                    res_fire = 1'b1;
                    res_err  = 1'b1;
                    state_d  = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        res_valid_o = '0;
        if (res_fire && !rst_i) res_valid_o[gnt_q] = 1'b1;
        res_data_o = (res_fire && !res_err && !rst_i) ? mem_res_data_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
        end
    end

`ifdef MEM_SCHED_TIMEOUT_EN
    // Counter idles at zero outside WAIT, so it is already cleared on WAIT entry.
    always_comb begin
        cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
        to_d  = to_q | (res_err && !rst_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign res_err_o = res_err && !rst_i;
    assign timeout_o = to_q;
`else
    assign res_err_o = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign busy_o         = (state_q != IDLE);
    assign mem_req_addr_o = addr_q;
    assign mem_req_data_o = data_q;
    assign mem_req_be_o   = be_q;

endmodule
